// File: rtl/otter_cu_fsm_if.sv
// rtl/otter_cu_fsm_if.sv - control-unit bus: decode inputs from the datapath, control strobes back to it
interface otter_cu_fsm_if;
  logic [6:0] opcode;
  logic       intr;
  logic       mem_valid;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] rf_wr_sel;
  logic       mem_rden1;
  logic       mem_rden2;
  logic       mem_we2;
  logic       int_taken;
  logic       load_err;
  logic       ill_op;

  modport master (
    input  opcode, intr, mem_valid,
    output pc_write, reg_write, rf_wr_sel, mem_rden1, mem_rden2, mem_we2,
           int_taken, load_err, ill_op
  );

  modport slave (
    output opcode, intr, mem_valid,
    input  pc_write, reg_write, rf_wr_sel, mem_rden1, mem_rden2, mem_we2,
           int_taken, load_err, ill_op
  );
endinterface

// File: rtl/otter_cu_fsm.sv
// rtl/otter_cu_fsm.sv - OTTER multicycle control FSM (FETCH/EXEC/WAIT_LD, INTR when OTTER_CU_INTR_EN)
module otter_cu_fsm #(
  parameter int unsigned LOAD_TIMEOUT = 15
) (
  input logic            CLK,
  input logic            RST_N,
  otter_cu_fsm_if.master cu
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

`ifdef OTTER_CU_INTR_EN
  typedef enum logic [1:0] {FETCH, EXEC, WAIT_LD, INTR} state_t;
`else
  typedef enum logic [1:0] {FETCH, EXEC, WAIT_LD} state_t;
`endif

  state_t     state;
  state_t     done_next;
  logic [7:0] ld_cnt;
  logic       is_load;
  logic       ld_timeout;
  logic       intr_req;

`ifdef OTTER_CU_INTR_EN
  assign intr_req = cu.intr;
`else
  logic unused_intr;
  assign unused_intr = cu.intr;
  assign intr_req    = 1'b0;
`endif

  // mem_valid beats the timeout when both land in the same cycle
  assign is_load    = (cu.opcode == OP_LOAD);
  assign ld_timeout = !cu.mem_valid && (ld_cnt == TIMEOUT_LAST);

  always_comb begin
    done_next = FETCH;
`ifdef OTTER_CU_INTR_EN
    if (intr_req) done_next = INTR;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= FETCH;
      ld_cnt <= '0;
    end else begin
      case (state)
        FETCH: state <= EXEC;
        EXEC: begin
          if (is_load) begin
            ld_cnt <= '0;
            state  <= WAIT_LD;
          end else begin
            state <= done_next;
          end
        end
        WAIT_LD: begin
          if (cu.mem_valid || ld_timeout) state <= done_next;
          else                            ld_cnt <= ld_cnt + 8'd1;
        end
`ifdef OTTER_CU_INTR_EN
        INTR: state <= FETCH;
`endif
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes are gated by RST_N so they drop the instant reset asserts
  always_comb begin
    cu.pc_write  = 1'b0;
    cu.reg_write = 1'b0;
    cu.rf_wr_sel = 2'b00;
    cu.mem_rden1 = 1'b0;
    cu.mem_rden2 = 1'b0;
    cu.mem_we2   = 1'b0;
    cu.int_taken = 1'b0;
    cu.load_err  = 1'b0;
    cu.ill_op    = 1'b0;
    if (RST_N) begin
      case (state)
        FETCH: cu.mem_rden1 = 1'b1;
        EXEC: begin
          case (cu.opcode)
            OP_OP, OP_IMM, OP_LUI, OP_AUIPC: begin
              cu.reg_write = 1'b1;
              cu.rf_wr_sel = 2'b11;
              cu.pc_write  = 1'b1;
            end
            OP_JAL, OP_JALR: begin
              cu.reg_write = 1'b1;
              cu.rf_wr_sel = 2'b00;
              cu.pc_write  = 1'b1;
            end
            OP_BRANCH: cu.pc_write = 1'b1;
            OP_STORE: begin
              cu.mem_we2  = 1'b1;
              cu.pc_write = 1'b1;
            end
            OP_SYSTEM: begin
              cu.reg_write = 1'b1;
              cu.rf_wr_sel = 2'b01;
              cu.pc_write  = 1'b1;
            end
            OP_LOAD: cu.mem_rden2 = 1'b1;
            default: begin
              cu.ill_op   = 1'b1;
              cu.pc_write = 1'b1;
            end
          endcase
        end
        WAIT_LD: begin
          if (cu.mem_valid) begin
            cu.reg_write = 1'b1;
            cu.rf_wr_sel = 2'b10;
            cu.pc_write  = 1'b1;
          end else if (ld_timeout) begin
            cu.load_err = 1'b1;
            cu.pc_write = 1'b1;
          end
        end
`ifdef OTTER_CU_INTR_EN
        INTR: begin
          cu.int_taken = 1'b1;
          cu.pc_write  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
